// File: rtl/path_delay_meter.sv
// path_delay_meter: measures delay-chain latency in clk cycles using a launch toggle and a 2-flop synchroniser.
// Define PATH_DELAY_ACCUM_EN to sum 8 consecutive trials per start on a CNT_W+3 bit delayCount.
module path_delay_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic pathResult,
  output logic pathInput,
  output logic busy,
  output logic measValid,
  output logic timedOut,
`ifdef PATH_DELAY_ACCUM_EN
  output logic [CNT_W+2:0] delayCount
`else
  output logic [CNT_W-1:0] delayCount
`endif
);
`ifdef PATH_DELAY_ACCUM_EN
  localparam int DW = CNT_W + 3;
`else
  localparam int DW = CNT_W;
`endif
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] LAUNCH  = 3'd2;
  localparam logic [2:0] MEASURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dly_q, dly_d, base;
  logic             pin_q, pin_d, to_q, to_d, sync1_q, sync2_q;
`ifdef PATH_DELAY_ACCUM_EN
  logic [DW-1:0] acc_q, acc_d;
  logic [2:0]    trial_q, trial_d;
  assign base = acc_q;
`else
  assign base = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    dly_d   = dly_q;
    to_d    = to_q;
`ifdef PATH_DELAY_ACCUM_EN
    acc_d   = acc_q;
    trial_d = trial_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        cnt_d   = '0;
`ifdef PATH_DELAY_ACCUM_EN
        acc_d   = '0;
        trial_d = '0;
`endif
      end
      SETTLE: if (sync2_q == pin_q) state_d = LAUNCH;
        else if (cnt_q == TO_M1) begin
          state_d = DONE;
          to_d    = 1'b1;
          dly_d   = base + DW'(TIMEOUT);
        end else cnt_d = cnt_q + 1'b1;
      LAUNCH: begin
        state_d = MEASURE;
        pin_d   = ~pin_q;
        cnt_d   = '0;
        to_d    = 1'b0;
      end
      MEASURE: if (sync2_q == pin_q) begin
`ifdef PATH_DELAY_ACCUM_EN
        acc_d = acc_q + DW'(cnt_q);
        if (trial_q == 3'd7) begin
          state_d = DONE;
          dly_d   = acc_d;
        end else begin
          state_d = SETTLE;
          trial_d = trial_q + 1'b1;
          cnt_d   = '0;
        end
`else
        state_d = DONE;
        dly_d   = DW'(cnt_q);
`endif
      end else if (cnt_q == TO) begin
        state_d = DONE;
        to_d    = 1'b1;
        dly_d   = base + DW'(TIMEOUT);
      end else cnt_d = cnt_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= 1'b0;
      dly_q   <= '0;
      to_q    <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef PATH_DELAY_ACCUM_EN
      acc_q   <= '0;
      trial_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      dly_q   <= dly_d;
      to_q    <= to_d;
      sync1_q <= pathResult;
      sync2_q <= sync1_q;
`ifdef PATH_DELAY_ACCUM_EN
      acc_q   <= acc_d;
      trial_q <= trial_d;
`endif
    end
  assign pathInput  = pin_q;
  assign busy       = state_q != IDLE;
  assign measValid  = state_q == DONE;
  assign timedOut   = to_q;
  assign delayCount = dly_q;
endmodule

// File: doc/path_delay_meter.md
PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the cycle counter.
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum cycles allowed for settling or measurement.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetN, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request one measurement; sampled on clk.
REQ-006 SHALL have port pathResult, input, 1: output of the delay chain, asynchronous to clk.
REQ-007 SHALL have port pathInput, output, 1: launch signal driven into the delay chain; driven from a flop.
REQ-008 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-009 SHALL have port measValid, output, 1: one-cycle pulse when a result is available.
REQ-010 SHALL have port timedOut, output, 1: qualifies measValid; high when the result is a timeout.
REQ-011 SHALL have port delayCount, output, CNT_W (CNT_W+3 with the macro defined): measured cycle count.

Function
REQ-012 SHALL synchronise pathResult through two flops (sync1, sync2); sync2 is the only consumer-visible sample.
REQ-013 SHALL treat the chain as non-inverting: settled when sync2 == pathInput.
REQ-014 SHALL implement FSM states IDLE, SETTLE, LAUNCH, MEASURE, DONE.
REQ-015 IDLE: start=1 -> SETTLE; start in any other state SHALL be ignored (no queueing).
REQ-016 SETTLE: counter increments each cycle; sync2 == pathInput -> LAUNCH; counter == TIMEOUT-1 -> DONE with timedOut=1.
REQ-017 LAUNCH: one cycle; pathInput toggles at this edge; counter cleared to 0 -> MEASURE.
REQ-018 MEASURE: counter increments each cycle; on the first edge at which sync2 equals the new pathInput, delayCount SHALL latch the number of edges since the toggle edge, inclusive of that edge -> DONE.
REQ-019 Zero-delay loopback (pathResult = pathInput) SHALL yield delayCount = 2.
REQ-020 MEASURE: counter reaching TIMEOUT without a match SHALL -> DONE with timedOut=1 and delayCount = TIMEOUT; the counter SHALL saturate, never wrap.
REQ-021 DONE: measValid=1 for exactly one cycle -> IDLE; delayCount and timedOut SHALL hold until the next LAUNCH or SETTLE timeout.
REQ-022 pathInput SHALL NOT be re-zeroed between measurements; successive measurements alternate rising and falling launches.
REQ-023 A pathResult glitch in MEASURE before the real edge SHALL be accepted as the arrival; no filtering is performed.

Reset
REQ-024 resetN low SHALL force IDLE, pathInput=0, sync1=sync2=0, counter=0, delayCount=0, measValid=0, timedOut=0, busy=0, asynchronously.
REQ-025 Reset asserted mid-measurement SHALL abort it with no measValid pulse; the first start after release SHALL run a full SETTLE.

Configuration
REQ-026 Macro PATH_DELAY_ACCUM_EN, when defined, SHALL run 8 consecutive SETTLE/LAUNCH/MEASURE trials per start and present their sum on delayCount (CNT_W+3 bits), with one measValid after the 8th trial.
REQ-027 With PATH_DELAY_ACCUM_EN defined, any trial timeout SHALL end the sequence immediately with timedOut=1 and delayCount = sum so far plus TIMEOUT.
REQ-028 With PATH_DELAY_ACCUM_EN undefined, one trial SHALL run per start and delayCount SHALL be CNT_W bits.

Verification
REQ-029 Loopback, start pulse after reset -> pathInput 0->1, measValid after ~6 cycles, delayCount=2, timedOut=0.
REQ-030 Chain model with 5-cycle delay, two starts -> delayCount=7 both, launches rising then falling.
REQ-031 pathResult tied 0, TIMEOUT=20 -> first start completes with delayCount=20, timedOut=1, busy low after DONE.
REQ-032 start held high through a measurement -> exactly one measValid per IDLE entry; no start lost or duplicated mid-run.
REQ-033 resetN pulsed low mid-MEASURE -> all outputs 0 immediately, no measValid; next start measures correctly.
REQ-034 PATH_DELAY_ACCUM_EN, loopback -> single measValid, delayCount=16.
